if_fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. Holds the PC and selects the next PC from sequential, branch, jump, jr, interrupt and exception sources. Runs a single-outstanding request/acknowledge handshake with instruction memory. Presents one instruction and its PC+4 per cycle to the IF/ID pipeline register, and holds the instruction while that register is protected (stalled).

---
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch: holds the PC, picks the next PC and runs a single-outstanding imem handshake.
// Outputs are combinational from state and inputs; IF_Protect parks the acked word in HOLD.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INT_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [2:0]  PCsrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic        IF_Protect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        IF_valid,
  output logic [31:0] IF_instruct,
  output logic [31:0] IF_PCplus4
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_q, hold_d;
  logic        req_q, req_d;
  logic        kill_q, kill_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_seq;

  // Bit 31 is the kernel bit: sequential fetch never carries into it.
  assign pc_seq = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    case (PCsrc)
      3'd1: begin redirect = 1'b1; redirect_pc = BranchTarget; end
      3'd2: begin redirect = 1'b1; redirect_pc = JumpTarget;   end
      3'd3: begin redirect = 1'b1; redirect_pc = JrTarget;     end
      3'd4: begin redirect = 1'b1; redirect_pc = INT_VEC;      end
      3'd5: begin redirect = 1'b1; redirect_pc = EXC_VEC;      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= '0;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    req_d   = req_q;
    kill_d  = kill_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem_ack) begin
            addr_d = redirect_pc;
            kill_d = 1'b0;
          end else begin
            // Request stays on the bus; its eventual ack is the one dropped.
            kill_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            addr_d = pc_q;
            kill_d = 1'b0;
          end else if (!IF_Protect) begin
            pc_d   = pc_seq;
            addr_d = pc_seq;
          end else begin
            hold_d  = imem_rdata;
            req_d   = 1'b0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          req_d   = 1'b1;
          hold_d  = '0;
          state_d = S_WAIT;
        end else if (!IF_Protect) begin
          pc_d    = pc_seq;
          addr_d  = pc_seq;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    IF_valid    = ((state_q == S_HOLD) || ((state_q == S_WAIT) && imem_ack && !kill_q)) && !redirect;
    IF_instruct = '0;
    IF_PCplus4  = '0;
    if (IF_valid) begin
      IF_instruct = (state_q == S_HOLD) ? hold_q : imem_rdata;
      IF_PCplus4  = pc_seq;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, hand sequences and a
// randomized run against a transaction-level fetch model with a variable-latency memory.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INT_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam int NV = 35;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  PCsrc = '0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0, JrTarget = '0;
  logic        IF_Protect = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        IF_valid;
  logic [31:0] IF_instruct, IF_PCplus4;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .INT_VEC(INT_VEC), .EXC_VEC(EXC_VEC)) dut (
    .CLK(clk), .Reset(rst), .PCsrc(PCsrc),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
    .IF_Protect(IF_Protect), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_valid(IF_valid), .IF_instruct(IF_instruct), .IF_PCplus4(IF_PCplus4)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] tgt;
    logic        prot;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;

  // Memory environment: acks after mem_lat cycles of an outstanding request.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  int          fix_lat = 1;
  bit          lat_rand = 1'b0;
  logic [31:0] dkey = '0;

  // Reference model state for the randomized run.
  logic [31:0] m_pc, m_addr, m_word, m_tgt;
  logic        m_req, m_stale, m_parked, m_redir, m_deliver;

  function automatic vec_t mk(input logic [2:0] src, input logic [31:0] tgt, input logic prot,
                              input logic ack, input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr);
    vec_t v;
    v.src = src; v.tgt = tgt; v.prot = prot; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc4 = e_pc4; v.e_instr = e_instr;
    return v;
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_vld, input logic [31:0] e_pc4, input logic [31:0] e_instr);
    chk({tag, " imem_req"},    32'(imem_req), 32'(e_req));
    chk({tag, " imem_addr"},   imem_addr,     e_addr);
    chk({tag, " IF_valid"},    32'(IF_valid), 32'(e_vld));
    chk({tag, " IF_PCplus4"},  IF_PCplus4,    e_pc4);
    chk({tag, " IF_instruct"}, IF_instruct,   e_instr);
  endtask

  // Selected target gets tgt, the others get distinct decoys so a wrong mux is visible.
  task automatic drive_tgt(input logic [2:0] src, input logic [31:0] tgt);
    BranchTarget = ~tgt;
    JumpTarget   = ~tgt ^ 32'h0000_0010;
    JrTarget     = ~tgt ^ 32'h0000_0020;
    case (src)
      3'd1: BranchTarget = tgt;
      3'd2: JumpTarget   = tgt;
      3'd3: JrTarget     = tgt;
      default: ;
    endcase
  endtask

  task automatic mem_drive();
    imem_ack   = imem_req && (mem_cnt >= mem_lat - 1);
    imem_rdata = imem_ack ? (imem_addr ^ dkey) : $urandom;
  endtask

  task automatic mem_advance();
    if (!imem_req || imem_ack) begin
      mem_cnt = 0;
      mem_lat = lat_rand ? int'($urandom_range(1, 3)) : fix_lat;
    end else begin
      mem_cnt++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    PCsrc = '0; IF_Protect = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_cnt = 0;
    mem_lat = lat_rand ? int'($urandom_range(1, 3)) : fix_lat;
  endtask

  initial begin
    int r;
    // src, tgt, prot, ack, rdata | req, addr, valid, pc4, instr
    tbl[0]  = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0000, 1'b0, 32'h0,         32'h0);
    tbl[1]  = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004, 32'h8000_0000);
    tbl[2]  = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0008, 32'h8000_0004);
    tbl[3]  = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_000C, 32'h8000_0008);
    tbl[4]  = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_000C, 1'b0, 32'h0,         32'h0);
    tbl[5]  = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0010, 32'h8000_000C);
    tbl[6]  = mk(3'd0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF);
    tbl[7]  = mk(3'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF);
    tbl[8]  = mk(3'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF);
    tbl[9]  = mk(3'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF);
    tbl[10] = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 1'b1, 32'h8000_0014, 32'hDEAD_BEEF);
    tbl[11] = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014, 1'b0, 32'h0,         32'h0);
    tbl[12] = mk(3'd1, 32'h0040_0100, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0014, 1'b0, 32'h0,         32'h0);
    tbl[13] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b1, 32'h8000_0014, 1'b0, 32'h0,         32'h0);
    tbl[14] = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0100, 1'b0, 32'h0,         32'h0);
    tbl[15] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0104, 32'hCAFE_F00D);
    tbl[16] = mk(3'd2, 32'h1234_5678, 1'b0, 1'b1, 32'h5555_5555, 1'b1, 32'h0040_0104, 1'b0, 32'h0,         32'h0);
    tbl[17] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h0BAD_C0DE, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_567C, 32'h0BAD_C0DE);
    tbl[18] = mk(3'd0, 32'h0,         1'b1, 1'b1, 32'h7777_7777, 1'b1, 32'h1234_567C, 1'b1, 32'h1234_5680, 32'h7777_7777);
    tbl[19] = mk(3'd4, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h1234_567C, 1'b0, 32'h0,         32'h0);
    tbl[20] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0008, 32'h8000_0004);
    tbl[21] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_000C, 32'h8000_0008);
    tbl[22] = mk(3'd3, 32'h7FFF_FFFC, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h8000_000C, 1'b0, 32'h0,         32'h0);
    tbl[23] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h7FFF_FFFC, 1'b1, 32'h7FFF_FFFC, 1'b1, 32'h0000_0000, 32'h7FFF_FFFC);
    tbl[24] = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0);
    tbl[25] = mk(3'd1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1212_1212, 1'b1, 32'h0000_0000, 1'b0, 32'h0,         32'h0);
    tbl[26] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h8000_0000, 32'hFFFF_FFFC);
    tbl[27] = mk(3'd0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0);
    tbl[28] = mk(3'd6, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004, 32'h8000_0000);
    tbl[29] = mk(3'd5, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004, 1'b0, 32'h0,         32'h0);
    tbl[30] = mk(3'd3, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004, 1'b0, 32'h0,         32'h0);
    tbl[31] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h3333_3333, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         32'h0);
    tbl[32] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0044, 32'h0000_0040);
    tbl[33] = mk(3'd0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0044, 1'b0, 32'h0,         32'h0);
    tbl[34] = mk(3'd0, 32'h0,         1'b0, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0048, 32'h0000_0044);

    // Reset state, with a stray ack on the bus that must not produce output.
    imem_ack = 1'b1;
    imem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check_outs("reset", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      PCsrc      = tbl[i].src;
      drive_tgt(tbl[i].src, tbl[i].tgt);
      IF_Protect = tbl[i].prot;
      imem_ack   = tbl[i].ack;
      imem_rdata = tbl[i].rdata;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                 tbl[i].e_pc4, tbl[i].e_instr);
      @(negedge clk);
    end

    // Fixed 3-cycle memory: one instruction every third cycle, address stable in between.
    fix_lat = 3; lat_rand = 1'b0; dkey = '0;
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      PCsrc = '0; IF_Protect = 1'b0;
      mem_drive();
      #1;
      if (c == 0) begin
        chk("lat3 idle imem_req", 32'(imem_req), 32'h0);
      end else begin
        chk($sformatf("lat3 c%0d imem_addr", c), imem_addr, RESET_PC + 32'(4 * ((c - 1) / 3)));
        chk($sformatf("lat3 c%0d IF_valid", c), 32'(IF_valid), 32'(c % 3 == 0));
        if (c % 3 == 0)
          chk($sformatf("lat3 c%0d IF_PCplus4", c), IF_PCplus4, RESET_PC + 32'(4 * ((c - 1) / 3)) + 32'd4);
      end
      mem_advance();
      @(negedge clk);
    end

    // Reset while a request is outstanding, then a late ack during IDLE.
    mem_drive();
    #1;
    chk("rstmid pre imem_req", 32'(imem_req), 32'h1);
    chk("rstmid pre IF_valid", 32'(IF_valid), 32'h0);
    rst = 1'b1;
    #1;
    check_outs("rstmid", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    chk("late ack IF_valid", 32'(IF_valid), 32'h0);
    chk("late ack IF_instruct", IF_instruct, 32'h0);
    chk("late ack imem_req", 32'(imem_req), 32'h0);
    @(negedge clk);

    // Randomized run against the fetch model.
    lat_rand = 1'b1;
    dkey = $urandom;
    apply_reset();
    m_pc = RESET_PC; m_addr = RESET_PC; m_word = '0;
    m_req = 1'b0; m_stale = 1'b0; m_parked = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      PCsrc = (r < 85) ? 3'd0 : 3'($urandom_range(1, 7));
      BranchTarget = $urandom; JumpTarget = $urandom; JrTarget = $urandom;
      IF_Protect = ($urandom_range(0, 2) == 0);
      mem_drive();

      m_redir = 1'b1;
      case (PCsrc)
        3'd1: m_tgt = BranchTarget;
        3'd2: m_tgt = JumpTarget;
        3'd3: m_tgt = JrTarget;
        3'd4: m_tgt = INT_VEC;
        3'd5: m_tgt = EXC_VEC;
        default: begin m_tgt = '0; m_redir = 1'b0; end
      endcase
      m_deliver = !m_redir && (m_parked || (m_req && imem_ack && !m_stale));

      #1;
      check_outs($sformatf("rnd%0d", n), m_req, m_addr, m_deliver,
                 m_deliver ? seq_pc(m_pc) : 32'h0,
                 m_deliver ? (m_parked ? m_word : imem_rdata) : 32'h0);
      if (IF_valid)
        chk($sformatf("rnd%0d memword", n), IF_instruct,
            {IF_PCplus4[31], IF_PCplus4[30:0] - 31'd4} ^ dkey);

      if (!m_req && !m_parked) begin
        m_req = 1'b1; m_addr = m_pc;
      end else if (m_redir) begin
        m_pc = m_tgt;
        if (m_parked || imem_ack) begin
          m_addr = m_tgt; m_req = 1'b1; m_stale = 1'b0; m_parked = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end else if (m_parked) begin
        if (!IF_Protect) begin
          m_pc = seq_pc(m_pc); m_addr = m_pc; m_req = 1'b1; m_parked = 1'b0;
        end
      end else if (imem_ack) begin
        if (m_stale) begin
          m_addr = m_pc; m_stale = 1'b0;
        end else if (!IF_Protect) begin
          m_pc = seq_pc(m_pc); m_addr = m_pc;
        end else begin
          m_word = imem_rdata; m_parked = 1'b1; m_req = 1'b0;
        end
      end

      mem_advance();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
